// File: rtl/capture_ctrl.sv
// Capture sequencer: fills a circular sample RAM, waits for a trigger and then
// records a fixed number of post-trigger samples before reporting done.
module capture_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] pin,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] trig_en,
  input  logic [DATA_W-1:0] trig_val,
  input  logic [ADDR_W-1:0] post_cnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);

  // state     | meaning
  // IDLE      | no capture armed
  // FILL      | collecting pre-trigger history, triggers ignored
  // WAIT_TRIG | history full, overwriting oldest until a match
  // POST      | recording post-trigger samples
  // DONE      | capture complete, buffer frozen
  typedef enum logic [2:0] {IDLE, FILL, WAIT_TRIG, POST, DONE} state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] post_left;
  logic [ADDR_W-1:0] post_lat;
  logic              capturing;
  logic              match;
  logic              fill_last;
  logic [ADDR_W:0]   fill_target;

  assign capturing   = (state == FILL) || (state == WAIT_TRIG) || (state == POST);
  assign match       = ((pin & trig_en) == trig_val);
  // History length is whatever the post-trigger window leaves free.
  assign fill_target = {1'b1, {ADDR_W{1'b0}}} - {1'b0, post_lat};
  assign fill_last   = (({1'b0, fill_cnt} + (ADDR_W+1)'(1)) == fill_target);
  assign busy        = capturing;
  assign done        = (state == DONE);

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (arm) state_nx = FILL;
        FILL:       if (sample_en && fill_last) state_nx = WAIT_TRIG;
        WAIT_TRIG:  if (sample_en && match)
                      state_nx = (post_lat == ADDR_W'(1)) ? DONE : POST;
        POST:       if (sample_en && post_left == ADDR_W'(1)) state_nx = DONE;
        default:    state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      post_left  <= '0;
      post_lat   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      triggered  <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
    end else begin
      state  <= state_nx;
      mem_we <= 1'b0;
      if (abort) begin
        triggered <= 1'b0;
      end else begin
        if (capturing && sample_en) begin
          mem_we   <= 1'b1;
          mem_addr <= wr_ptr;
          mem_din  <= pin;
          wr_ptr   <= wr_ptr + ADDR_W'(1);
        end
        case (state)
          IDLE, DONE: begin
            if (arm) begin
              post_lat   <= (post_cnt == '0) ? ADDR_W'(1) : post_cnt;
              wr_ptr     <= '0;
              fill_cnt   <= '0;
              triggered  <= 1'b0;
              trig_addr  <= '0;
              start_addr <= '0;
            end
          end
          FILL: if (sample_en) fill_cnt <= fill_cnt + ADDR_W'(1);
          WAIT_TRIG: begin
            if (sample_en && match) begin
              trig_addr <= wr_ptr;
              triggered <= 1'b1;
              post_left <= post_lat - ADDR_W'(1);
              if (post_lat == ADDR_W'(1)) start_addr <= wr_ptr + ADDR_W'(1);
            end
          end
          POST: begin
            if (sample_en) begin
              post_left <= post_left - ADDR_W'(1);
              // Oldest sample sits just past the final write.
              if (post_left == ADDR_W'(1)) start_addr <= wr_ptr + ADDR_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Sequences one capture into the dual-port sample RAM: arm, pre-trigger fill, trigger wait, post-trigger count, done.
- Treats the RAM as a circular buffer, so the pre-trigger history and the post-trigger samples coexist.
- Driven by the register/UART controller (arm, abort, trigger config) and by the sample-clock strobe; drives the RAM write port.
- Reports trigger and oldest-sample addresses for readback.

Parameters:
- ADDR_W, 14, RAM address width; DEPTH = 2^ADDR_W samples.
- DATA_W, 8, sample width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sample_en  in  1  one-cycle strobe per sample period.
- pin  in  DATA_W  probe inputs, already synchronised.
- arm  in  1  one-cycle pulse; starts a capture.
- abort  in  1  one-cycle pulse; cancels a capture.
- trig_en  in  DATA_W  trigger mask.
- trig_val  in  DATA_W  trigger compare value.
- post_cnt  in  ADDR_W  post-trigger sample count, trigger sample included.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM write address.
- mem_din  out  DATA_W  RAM write data.
- busy  out  1  capture in progress.
- triggered  out  1  trigger seen in the current capture.
- done  out  1  capture complete.
- trig_addr  out  ADDR_W  address holding the trigger sample.
- start_addr  out  ADDR_W  address of the oldest valid sample.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Internal wr_ptr, fill_cnt, post_left, post_lat all 0.
- States and busy/done:
  - IDLE, FILL, WAIT_TRIG, POST, DONE.
  - busy = state in {FILL, WAIT_TRIG, POST}.
  - done = (state == DONE).
- Arm, IDLE or DONE only:
  - post_lat <= (post_cnt == 0) ? 1 : post_cnt; wr_ptr <= 0; fill_cnt <= 0.
  - triggered <= 0; trig_addr <= 0; start_addr <= 0; next state FILL.
  - Arm in FILL, WAIT_TRIG or POST is ignored.
- Abort, any state:
  - Next state IDLE.
  - mem_we forced 0 on the following cycle.
  - triggered <= 0; done drops.
  - Abort wins over arm in the same cycle.
- Sample write, in FILL/WAIT_TRIG/POST with sample_en = 1:
  - Next cycle: mem_we = 1, mem_addr = wr_ptr, mem_din = pin as sampled at the strobe.
  - wr_ptr <= wr_ptr + 1, modulo DEPTH (wraps silently).
  - mem_we is high for exactly one cycle per strobe and is never high outside these states.
- Trigger match: (pin & trig_en) == trig_val, evaluated only on sample_en cycles.
- FILL:
  - Each strobe increments fill_cnt.
  - When fill_cnt reaches DEPTH - post_lat (counting this strobe), go to WAIT_TRIG.
  - Matches during FILL are ignored.
- WAIT_TRIG:
  - Strobe without a match: write the sample, stay.
  - Strobe with a match: write the sample; trig_addr <= wr_ptr; triggered <= 1; post_left <= post_lat - 1.
  - Then go to DONE if post_lat == 1, else to POST.
- POST:
  - Each strobe writes a sample and decrements post_left.
  - The strobe that brings post_left to 0 moves to DONE.
  - start_addr <= wr_ptr value after that write's increment, i.e. oldest = trig_addr + post_lat mod DEPTH.
- DONE:
  - Holds outputs; no writes.
  - done stays high until arm or abort.
- Buffer content at DONE: DEPTH contiguous samples from start_addr; DEPTH - post_lat are pre-trigger.
- Latency:
  - Strobe to mem_we: 1 cycle.
  - Final strobe to done: 1 cycle.
- Configuration timing: trig_en and trig_val are used live; post_cnt is latched only at arm.
- Asynchronous reset mid-capture: immediate return to reset values, with no clock edge needed.

Test Plan:
- ADDR_W=4, post_cnt=4, trig_en=0xFF, trig_val=0x14, pin = sample index, sample_en every 3rd cycle, arm -> values 0..11 at addr 0..11, WAIT_TRIG; 20 written at addr 4, trig_addr=4, triggered=1; 20..23 at addr 4..7; done=1, start_addr=8; RAM read from addr 8 wrapping = 8..23.
- ADDR_W=4, post_cnt=4, trig_en=0x00, trig_val=0x00 (always match) -> 12 FILL writes, trigger on 13th, trig_addr=12, 16 writes total, start_addr=0, done=1.
- pin matches trigger on FILL sample 2 only -> no trigger; capture stays in WAIT_TRIG, wr_ptr wraps 15->0, busy=1, done=0.
- abort during POST -> next cycle state IDLE, mem_we=0 thereafter, busy=0, triggered=0, done=0; arm while busy -> no effect; arm+abort same cycle from DONE -> IDLE.
- post_cnt=0, ADDR_W=4 -> treated as 1: 15 FILL samples, done 1 cycle after the trigger strobe, start_addr = trig_addr+1.
- rst_n low between clock edges mid-FILL -> all outputs 0 immediately; after release, no mem_we until a new arm.
